alu_control_seq: RTL and testbench

//  Registered, handshaked successor to the single-cycle ALU control decoder.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_op_decoder.sv | 58 +++++
 rtl/alu_control_seq.sv | 98 +++++++++
 tb/tb_alu_control_seq.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU control encodings and the sequencer state type.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_SUBU = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1110;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_MUL  = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SUBU = 6'b100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_ANDI  = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/alu_op_decoder.sv
// alu_op_decoder: combinational ALUOp/funct to ALU operation decode.
//   alu_op_i     [1:0] ALUOp from ID/EX control
//   funct_i      [5:0] R-type funct field
//   operation_o  [3:0] decoded ALU operation
//   is_mul_o           multiply, routed to the MDU
//   is_div_o           divide, routed to the MDU
//   illegal_o          unknown funct, or mul/div while the MDU is disabled
module alu_op_decoder
    import alu_pkg::*;
#(
    parameter int ENABLE_MULDIV = 1
) (
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] operation_o,
    output logic       is_mul_o,
    output logic       is_div_o,
    output logic       illegal_o
);
    localparam bit MD = ENABLE_MULDIV != 0;

    always_comb begin
        operation_o = OP_ADD;
        is_mul_o    = 1'b0;
        is_div_o    = 1'b0;
        illegal_o   = 1'b0;
        case (alu_op_i)
            ALUOP_ADD:  operation_o = OP_ADD;
            ALUOP_ANDI: operation_o = OP_AND;
            ALUOP_ORI:  operation_o = OP_OR;
            default:
                case (funct_i)
                    FUNCT_ADD:  operation_o = OP_ADD;
                    FUNCT_SUB:  operation_o = OP_SUB;
                    FUNCT_SLL:  operation_o = OP_SLL;
                    FUNCT_SRL:  operation_o = OP_SRL;
                    FUNCT_AND:  operation_o = OP_AND;
                    FUNCT_OR:   operation_o = OP_OR;
                    FUNCT_XOR:  operation_o = OP_XOR;
                    FUNCT_NOR:  operation_o = OP_NOR;
                    FUNCT_SLT:  operation_o = OP_SLT;
                    FUNCT_ADDU: operation_o = OP_ADDU;
                    FUNCT_SUBU: operation_o = OP_SUBU;
                    FUNCT_MUL: begin
                        operation_o = MD ? OP_MUL : OP_ADD;
                        is_mul_o    = MD;
                        illegal_o   = !MD;
                    end
                    FUNCT_DIV: begin
                        operation_o = MD ? OP_DIV : OP_ADD;
                        is_div_o    = MD;
                        illegal_o   = !MD;
                    end
                    default:    illegal_o = 1'b1;
                endcase
        endcase
    end
endmodule

// File: rtl/alu_control_seq.sv
// alu_control_seq: registered, handshaked ALU control decoder sequencing multi-cycle MUL/DIV.
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   flush      synchronous pipeline flush, aborts any MDU op in flight
//   in_valid   ALUOp/FuncField valid
//   in_ready   block can accept (IDLE)
//   ALUOp      [1:0] 00 add, 01 andi, 10 R-type, 11 ori
//   FuncField  [5:0] R-type funct
//   out_valid  one-cycle pulse, Operation valid for the consumer
//   Operation  [3:0] ALU op code, held until the next accept
//   mdu_start  one-cycle pulse starting the MDU
//   stall      holds the upstream pipeline while BUSY
//   illegal    registered with Operation: unknown or disabled funct
module alu_control_seq
    import alu_pkg::*;
#(
    parameter int MUL_CYCLES    = 4,
    parameter int DIV_CYCLES    = 16,
    parameter int ENABLE_MULDIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] ALUOp,
    input  logic [5:0] FuncField,
    output logic       out_valid,
    output logic [3:0] Operation,
    output logic       mdu_start,
    output logic       stall,
    output logic       illegal
);
    localparam int MAX_LAT = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [3:0]       op_q;
    logic             ill_q, ov_q, ms_q;
    logic [3:0]       dec_op;
    logic             dec_mul, dec_div, dec_ill;

    alu_op_decoder #(.ENABLE_MULDIV(ENABLE_MULDIV)) u_dec (
        .alu_op_i    (ALUOp),
        .funct_i     (FuncField),
        .operation_o (dec_op),
        .is_mul_o    (dec_mul),
        .is_div_o    (dec_div),
        .illegal_o   (dec_ill)
    );

    // Counter is loaded with LAT-1 so the final BUSY edge (cnt==0) lands exactly LAT edges after accept.
    assign cnt_d = dec_mul ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_ADD;
            ill_q   <= 1'b0;
            ov_q    <= 1'b0;
            ms_q    <= 1'b0;
        end else begin
            ov_q <= 1'b0;
            ms_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
                cnt_q   <= '0;
            end else if (state_q == BUSY) begin
                if (cnt_q == '0) begin
                    state_q <= IDLE;
                    ov_q    <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (in_valid) begin
                op_q  <= dec_op;
                ill_q <= dec_ill;
                if (dec_mul || dec_div) begin
                    state_q <= BUSY;
                    cnt_q   <= cnt_d;
                    ms_q    <= 1'b1;
                end else begin
                    ov_q <= 1'b1;
                end
            end
        end
    end

    assign in_ready  = state_q == IDLE;
    assign stall     = state_q == BUSY;
    assign out_valid = ov_q;
    assign Operation = op_q;
    assign mdu_start = ms_q;
    assign illegal   = ill_q;
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: three parameterisations driven in lockstep against a time-based reference model.
module tb_alu_control_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [1:0] ALUOp = 2'b00;
    logic [5:0] FuncField = 6'b000000;

    logic [2:0] rdy, ov, ms, st, il;
    logic [3:0] opo [3];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // instance 0: 4/16 enabled, 1: 1/2 enabled, 2: 4/16 muldiv disabled
    int  mlat [3] = '{4, 1, 4};
    int  dlat [3] = '{16, 2, 16};
    bit  en   [3] = '{1'b1, 1'b1, 1'b0};

    logic [5:0] fn_tab [13] = '{6'b100000, 6'b100010, 6'b011000, 6'b011010, 6'b000000, 6'b000010,
                                6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b100001, 6'b100011};
    logic [3:0] op_tab [13] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1110, 4'b0110, 4'b0111};

    bit         pend    [3];
    int         done_at [3];
    logic [3:0] m_op    [3];
    logic       m_ill   [3];
    logic       m_ov    [3];
    logic       m_ms    [3];

    always #5 clk = ~clk;

    alu_control_seq #(.MUL_CYCLES(4), .DIV_CYCLES(16), .ENABLE_MULDIV(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .ALUOp(ALUOp), .FuncField(FuncField), .out_valid(ov[0]), .Operation(opo[0]),
        .mdu_start(ms[0]), .stall(st[0]), .illegal(il[0]));
    alu_control_seq #(.MUL_CYCLES(1), .DIV_CYCLES(2), .ENABLE_MULDIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .ALUOp(ALUOp), .FuncField(FuncField), .out_valid(ov[1]), .Operation(opo[1]),
        .mdu_start(ms[1]), .stall(st[1]), .illegal(il[1]));
    alu_control_seq #(.MUL_CYCLES(4), .DIV_CYCLES(16), .ENABLE_MULDIV(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .ALUOp(ALUOp), .FuncField(FuncField), .out_valid(ov[2]), .Operation(opo[2]),
        .mdu_start(ms[2]), .stall(st[2]), .illegal(il[2]));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // sel: 0 single-cycle, 1 multiply, 2 divide
    task automatic ref_dec(input logic [1:0] a, input logic [5:0] f, input bit e,
                           output logic [3:0] op, output logic ill, output int sel);
        op = 4'b0000; ill = 1'b0; sel = 0;
        if (a == 2'b01) op = 4'b1000;
        else if (a == 2'b11) op = 4'b1001;
        else if (a == 2'b10) begin
            ill = 1'b1;
            for (int k = 0; k < 13; k++)
                if (fn_tab[k] == f) begin op = op_tab[k]; ill = 1'b0; end
            if (f == 6'b011000 || f == 6'b011010) begin
                if (e) sel = (f == 6'b011000) ? 1 : 2;
                else begin op = 4'b0000; ill = 1'b1; end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            pend[i] = 1'b0; done_at[i] = 0; m_op[i] = 4'b0000;
            m_ill[i] = 1'b0; m_ov[i] = 1'b0; m_ms[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [3:0] op;
        logic ill;
        int sel;
        cyc++;
        for (int i = 0; i < 3; i++) begin
            m_ov[i] = 1'b0;
            m_ms[i] = 1'b0;
            if (flush) pend[i] = 1'b0;
            else if (pend[i]) begin
                if (cyc == done_at[i]) begin pend[i] = 1'b0; m_ov[i] = 1'b1; end
            end else if (in_valid) begin
                ref_dec(ALUOp, FuncField, en[i], op, ill, sel);
                m_op[i] = op;
                m_ill[i] = ill;
                if (sel != 0) begin
                    pend[i] = 1'b1;
                    done_at[i] = cyc + (sel == 1 ? mlat[i] : dlat[i]);
                    m_ms[i] = 1'b1;
                end else m_ov[i] = 1'b1;
            end
        end
    endtask

    task automatic chk_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("out_valid[%0d]", i), 4'(ov[i]), 4'(m_ov[i]));
            chk($sformatf("Operation[%0d]", i), opo[i], m_op[i]);
            chk($sformatf("illegal[%0d]", i), 4'(il[i]), 4'(m_ill[i]));
            chk($sformatf("mdu_start[%0d]", i), 4'(ms[i]), 4'(m_ms[i]));
            chk($sformatf("stall[%0d]", i), 4'(st[i]), 4'(pend[i]));
            chk($sformatf("in_ready[%0d]", i), 4'(rdy[i]), 4'(!pend[i]));
        end
    endtask

    task automatic step(input logic v, input logic [1:0] a, input logic [5:0] f, input logic fl);
        in_valid = v; ALUOp = a; FuncField = f; flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        chk_all();
        in_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid[%0d]", i), 4'(ov[i]), 4'b0);
            chk($sformatf("rst_mdu_start[%0d]", i), 4'(ms[i]), 4'b0);
            chk($sformatf("rst_stall[%0d]", i), 4'(st[i]), 4'b0);
            chk($sformatf("rst_illegal[%0d]", i), 4'(il[i]), 4'b0);
            chk($sformatf("rst_Operation[%0d]", i), opo[i], 4'b0000);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all();

        // single-cycle ops, back-to-back
        step(1'b1, 2'b10, 6'b100010, 1'b0);
        chk("t2_sub_op", opo[0], 4'b0001);
        step(1'b1, 2'b01, 6'b000000, 1'b0);
        chk("t2_andi_op", opo[0], 4'b1000);
        step(1'b1, 2'b11, 6'b000000, 1'b0);
        chk("t2_ori_op", opo[0], 4'b1001);
        step(1'b1, 2'b00, 6'b000000, 1'b0);
        chk("t2_add_ov", 4'(ov[0]), 4'b1);
        step(1'b0, 2'b00, 6'b000000, 1'b0);

        // multiply with in_valid held during BUSY
        step(1'b1, 2'b10, 6'b011000, 1'b0);
        chk("t3_start", 4'(ms[0]), 4'b1);
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 2'b01, 6'b000000, 1'b0);
            if (k == 4) chk("t3_mul_done_op", opo[0], 4'b0010);
        end

        // divide aborted by flush at E0+5, then a fresh add
        step(1'b1, 2'b10, 6'b011010, 1'b0);
        repeat (4) step(1'b0, 2'b00, 6'b000000, 1'b0);
        step(1'b0, 2'b00, 6'b000000, 1'b1);
        chk("t4_ready_after_flush", 4'(rdy[0]), 4'b1);
        step(1'b1, 2'b00, 6'b000000, 1'b0);
        chk("t4_add_ov", 4'(ov[0]), 4'b1);

        // illegal funct, and mul with muldiv disabled
        step(1'b1, 2'b10, 6'b111111, 1'b0);
        chk("t5_illegal", 4'(il[0]), 4'b1);
        step(1'b1, 2'b10, 6'b011000, 1'b0);
        chk("t5_dis_illegal", 4'(il[2]), 4'b1);
        chk("t5_dis_nostall", 4'(st[2]), 4'b0);
        repeat (5) step(1'b0, 2'b00, 6'b000000, 1'b0);

        // LAT=1 multiply, then flush coincident with in_valid
        step(1'b1, 2'b10, 6'b011000, 1'b0);
        step(1'b0, 2'b00, 6'b000000, 1'b0);
        chk("t6_lat1_ov", 4'(ov[1]), 4'b1);
        step(1'b1, 2'b10, 6'b011000, 1'b0);
        step(1'b1, 2'b01, 6'b000000, 1'b1);
        chk("t6_flush_drop", 4'(ov[2]), 4'b0);
        step(1'b0, 2'b00, 6'b000000, 1'b0);

        // async reset in the middle of a divide
        step(1'b1, 2'b10, 6'b011010, 1'b0);
        repeat (2) step(1'b0, 2'b00, 6'b000000, 1'b0);
        do_reset();
        repeat (20) step(1'b0, 2'b00, 6'b000000, 1'b0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int idx;
            logic [5:0] f;
            idx = $urandom_range(0, 15);
            f = idx < 13 ? fn_tab[idx] : 6'($urandom);
            step(1'($urandom_range(0, 9) < 7), 2'($urandom), f, 1'($urandom_range(0, 29) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
